// File: rtl/pc_ras_unit.sv
// ---------------------------------------------------------------------------
// pc_ras_unit
//
// Program counter for the front of the fetch stage. Holds the current fetch
// address and picks the next one from a return-address-stack pop, an
// absolute jump (optionally a call that pushes the return address), a
// PC-relative branch, or a plain increment. A circular return-address stack
// tracks calls and returns and reports overflow and underflow.
//
// Optional feature macro: PC_BYTE_ADDR_EN
//   undefined : word addressing, INC = 1, branch offset used as-is
//   defined   : byte addressing, INC = 4, branch offset scaled by 4,
//               jump target and reset vector forced to word alignment
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   stall          hold all state, ignore other controls
//   branch         take PC-relative branch (pc_inc + offset)
//   branch_offset  signed branch offset
//   jump           take absolute jump to jump_target
//   jump_target    absolute jump destination
//   call           with jump: push pc_inc onto the RAS
//   ret            pop the RAS and redirect to the popped address
//   pc             registered fetch address
//   pc_inc         pc + INC (combinational)
//   ras_count      number of valid RAS entries (0..RAS_DEPTH)
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_ovf        sticky: a push hit a full RAS
//   ret_unf        one-cycle pulse: ret accepted with an empty RAS
// ---------------------------------------------------------------------------
module pc_ras_unit #(
   parameter int                 WIDTH     = 32,
   parameter int                 RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           branch,
   input  logic [WIDTH-1:0]               branch_offset,
   input  logic                           jump,
   input  logic [WIDTH-1:0]               jump_target,
   input  logic                           call,
   input  logic                           ret,
   output logic [WIDTH-1:0]               pc,
   output logic [WIDTH-1:0]               pc_inc,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           ras_empty,
   output logic                           ras_full,
   output logic                           ras_ovf,
   output logic                           ret_unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

`ifdef PC_BYTE_ADDR_EN
   localparam logic [WIDTH-1:0] INC      = WIDTH'(4);
   localparam logic [WIDTH-1:0] RESET_PC = RESET_VEC & ~WIDTH'(3);
`else
   localparam logic [WIDTH-1:0] INC      = WIDTH'(1);
   localparam logic [WIDTH-1:0] RESET_PC = RESET_VEC;
`endif

   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PTR_W-1:0] top_ptr;
   logic [WIDTH-1:0] eff_offset;
   logic [WIDTH-1:0] eff_target;
   logic [WIDTH-1:0] top_entry;
   logic [WIDTH-1:0] next_pc;
   logic             ret_hit;
   logic             ret_miss;
   logic             do_push;

   assign pc_inc    = pc + INC;
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

`ifdef PC_BYTE_ADDR_EN
   assign eff_offset = branch_offset << 2;
   assign eff_target = {jump_target[WIDTH-1:2], 2'b00};
`else
   assign eff_offset = branch_offset;
   assign eff_target = jump_target;
`endif

   // top_ptr names the next free slot, so the most recent entry sits one
   // below it; wrapping both ways gives the circular overwrite-oldest stack.
   assign top_entry = stack[top_ptr - PTR_W'(1)];

   // A ret always wins over jump/call, so the push is suppressed whenever
   // ret is present, even when the RAS is empty.
   assign ret_hit  = !stall && ret && !ras_empty;
   assign ret_miss = !stall && ret && ras_empty;
   assign do_push  = !stall && !ret && jump && call;

   always_comb begin
      next_pc = pc_inc;
      if (ret_hit)
         next_pc = top_entry;
      else if (ret)
         next_pc = pc_inc;
      else if (jump)
         next_pc = eff_target;
      else if (branch)
         next_pc = pc_inc + eff_offset;
   end

   // Control state: stall freezes everything except the underflow pulse,
   // which must drop after one cycle regardless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_PC;
         top_ptr   <= '0;
         ras_count <= '0;
         ras_ovf   <= 1'b0;
         ret_unf   <= 1'b0;
      end else if (stall) begin
         ret_unf <= 1'b0;
      end else begin
         pc      <= next_pc;
         ret_unf <= ret_miss;
         if (ret_hit) begin
            top_ptr   <= top_ptr - PTR_W'(1);
            ras_count <= ras_count - CNT_W'(1);
         end else if (do_push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (ras_full)
               ras_ovf <= 1'b1;
            else
               ras_count <= ras_count + CNT_W'(1);
         end
      end
   end

   // Stack storage needs no reset; entries are only read when counted valid.
   always_ff @(posedge clk) begin
      if (do_push)
         stack[top_ptr] <= pc_inc;
   end

endmodule

// File: tb/tb_pc_ras_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_ras_unit
//
// Directed bench for pc_ras_unit in its default word-addressed build. A
// 32-bit, 4-entry instance covers reset, increment, branch, call/return,
// overflow/underflow, stall and priority; an 8-bit instance covers address
// wrap-around. Inputs change 1 time unit after a rising edge and outputs
// are checked at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_pc_ras_unit;

   logic        clk;
   logic        rst;
   logic        stall, branch, jump, call, ret;
   logic [31:0] branch_offset, jump_target;
   logic [31:0] pc, pc_inc;
   logic [2:0]  ras_count;
   logic        ras_empty, ras_full, ras_ovf, ret_unf;

   logic        rst8;
   logic        branch8;
   logic [7:0]  offset8;
   logic [7:0]  pc8, pc_inc8;
   logic [1:0]  ras_count8;
   logic        ras_empty8, ras_full8, ras_ovf8, ret_unf8;

   int checks = 0;
   int errors = 0;

   pc_ras_unit #(.WIDTH(32), .RAS_DEPTH(4), .RESET_VEC(32'd0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .call(call), .ret(ret), .pc(pc), .pc_inc(pc_inc),
      .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ret_unf(ret_unf)
   );

   pc_ras_unit #(.WIDTH(8), .RAS_DEPTH(2), .RESET_VEC(8'd254)) dut8 (
      .clk(clk), .rst(rst8), .stall(1'b0), .branch(branch8),
      .branch_offset(offset8), .jump(1'b0), .jump_target(8'd0),
      .call(1'b0), .ret(1'b0), .pc(pc8), .pc_inc(pc_inc8),
      .ras_count(ras_count8), .ras_empty(ras_empty8), .ras_full(ras_full8),
      .ras_ovf(ras_ovf8), .ret_unf(ret_unf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic j,
                                input logic c, input logic b,
                                input logic [31:0] tgt, input logic [31:0] off);
      stall = s; ret = r; jump = j; call = c; branch = b;
      jump_target = tgt; branch_offset = off;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   initial begin
      rst = 1'b0; rst8 = 1'b0; branch8 = 1'b0; offset8 = 8'd0;
      idle();
      tick(); tick();

      // Reset state
      checkOutput("reset_pc", pc, 32'd0);
      checkOutput("reset_count", 32'(ras_count), 32'd0);
      checkOutput("reset_empty", 32'(ras_empty), 32'd1);
      checkOutput("reset_full", 32'(ras_full), 32'd0);
      checkOutput("reset_ovf", 32'(ras_ovf), 32'd0);
      checkOutput("reset_unf", 32'(ret_unf), 32'd0);
      checkOutput("reset_pc_inc", pc_inc, 32'd1);

      // Sequential increment
      rst = 1'b1;
      tick(); checkOutput("inc_1", pc, 32'd1);
      tick(); checkOutput("inc_2", pc, 32'd2);
      tick(); checkOutput("inc_3", pc, 32'd3);

      // Asynchronous reset mid-cycle, with a jump pending
      applyStimulus(0, 0, 1, 0, 0, 32'd77, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset_pc", pc, 32'd0);
      tick();
      checkOutput("reset_drops_jump", pc, 32'd0);
      rst = 1'b1;
      idle();

      // Branch: pc=10, offset -3 -> 8
      applyStimulus(0, 0, 1, 0, 0, 32'd10, 32'd0);
      tick(); checkOutput("jump_to_10", pc, 32'd10);
      applyStimulus(0, 0, 0, 0, 1, 32'd0, -32'sd3);
      tick(); checkOutput("branch_back", pc, 32'd8);
      checkOutput("branch_pc_inc", pc_inc, 32'd9);

      // Call without jump is ignored
      applyStimulus(0, 0, 0, 1, 0, 32'd500, 32'd0);
      tick(); checkOutput("call_only_pc", pc, 32'd9);
      checkOutput("call_only_count", 32'(ras_count), 32'd0);

      // Call/return
      applyStimulus(0, 0, 1, 0, 0, 32'd5, 32'd0);
      tick(); checkOutput("jump_to_5", pc, 32'd5);
      applyStimulus(0, 0, 1, 1, 0, 32'd100, 32'd0);
      tick(); checkOutput("call_pc", pc, 32'd100);
      checkOutput("call_count", 32'(ras_count), 32'd1);
      checkOutput("call_not_empty", 32'(ras_empty), 32'd0);
      idle();
      tick(); tick(); checkOutput("callee_inc", pc, 32'd102);
      applyStimulus(0, 1, 0, 0, 0, 32'd0, 32'd0);
      tick(); checkOutput("ret_pc", pc, 32'd6);
      checkOutput("ret_count", 32'(ras_count), 32'd0);
      checkOutput("ret_no_unf", 32'(ret_unf), 32'd0);

      // Overflow: five nested calls from 0,10,20,30,40
      applyStimulus(0, 0, 1, 0, 0, 32'd0, 32'd0);
      tick(); checkOutput("jump_to_0", pc, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 0, 1, 1, 0, 32'(i * 10), 32'd0);
         tick();
      end
      checkOutput("ovf_pc", pc, 32'd50);
      checkOutput("ovf_count", 32'(ras_count), 32'd4);
      checkOutput("ovf_full", 32'(ras_full), 32'd1);
      checkOutput("ovf_flag", 32'(ras_ovf), 32'd1);
      applyStimulus(0, 1, 0, 0, 0, 32'd0, 32'd0);
      tick(); checkOutput("pop_1", pc, 32'd41);
      checkOutput("pop_1_count", 32'(ras_count), 32'd3);
      tick(); checkOutput("pop_2", pc, 32'd31);
      tick(); checkOutput("pop_3", pc, 32'd21);
      tick(); checkOutput("pop_4", pc, 32'd11);
      checkOutput("pop_4_empty", 32'(ras_empty), 32'd1);
      tick(); checkOutput("unf_pc", pc, 32'd12);
      checkOutput("unf_pulse", 32'(ret_unf), 32'd1);
      checkOutput("unf_count", 32'(ras_count), 32'd0);
      idle();
      tick(); checkOutput("unf_pulse_end", 32'(ret_unf), 32'd0);
      checkOutput("after_unf_pc", pc, 32'd13);
      checkOutput("ovf_sticky", 32'(ras_ovf), 32'd1);

      // Stall holds pc and RAS against ret and jump
      applyStimulus(0, 0, 1, 1, 0, 32'd60, 32'd0);
      tick(); checkOutput("call_60", pc, 32'd60);
      applyStimulus(1, 1, 1, 0, 0, 32'd999, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_pc", pc, 32'd60);
         checkOutput("stall_count", 32'(ras_count), 32'd1);
      end

      // Jump beats branch
      applyStimulus(0, 0, 1, 0, 1, 32'd200, 32'd7);
      tick(); checkOutput("jump_over_branch", pc, 32'd200);

      // Ret beats jump+call: pop happens, push dropped
      applyStimulus(0, 1, 1, 1, 0, 32'd300, 32'd0);
      tick(); checkOutput("ret_over_call_pc", pc, 32'd14);
      checkOutput("ret_over_call_count", 32'(ras_count), 32'd0);
      idle();

      // Wrap on the 8-bit instance: 254 -> 255 -> 0, then branch -1 -> 0
      rst8 = 1'b1;
      checkOutput("w_reset", 32'(pc8), 32'd254);
      tick(); checkOutput("w_255", 32'(pc8), 32'd255);
      checkOutput("w_pc_inc", 32'(pc_inc8), 32'd0);
      tick(); checkOutput("w_wrap", 32'(pc8), 32'd0);
      branch8 = 1'b1; offset8 = 8'hFF;
      tick(); checkOutput("w_branch_neg1", 32'(pc8), 32'd0);
      branch8 = 1'b0;
      tick(); checkOutput("w_inc_after", 32'(pc8), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
